// File: rtl/std_switch_seq.sv
// std_switch_seq: sequences a glitch-free clock-select changeover across NUM_STD video standards.
// Optional macro STD_SWITCH_LOCK_TIMEOUT_EN adds a PLL lock timeout that falls back to the previous standard.
module std_switch_seq #(
    parameter int NUM_STD        = 2,
    parameter int SEL_W          = ($clog2(NUM_STD) < 1) ? 1 : $clog2(NUM_STD),
    parameter int DEFAULT_STD    = 0,
    parameter int DEBOUNCE_W     = 16,
    parameter int GATE_CYCLES    = 8,
    parameter int SETTLE_CYCLES  = 1024,
    parameter int RESET_HOLD     = 64,
    parameter int TIMEOUT_CYCLES = 1 << 20
) (
    input  logic               clk_col4x,
    input  logic               rst,
    input  logic               standard_sw,
    input  logic [NUM_STD-1:0] pll_locked,
    input  logic               req_valid,
    input  logic [SEL_W-1:0]   req_std,
    output logic [SEL_W-1:0]   chip_sel,
    output logic               clk_ce,
    output logic               rst_out,
    output logic               busy,
    output logic               switch_done,
    output logic               switch_err
);

    localparam int CNT_MAX_GS = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
    localparam int CNT_MAX    = (CNT_MAX_GS > RESET_HOLD) ? CNT_MAX_GS : RESET_HOLD;
    localparam int CNT_W      = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] GATE_LAST   = CNT_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RESET_HOLD - 1);
    localparam logic [SEL_W-1:0] SEL_DEF     = SEL_W'(DEFAULT_STD);
    localparam logic [SEL_W-1:0] SEL_LAST    = SEL_W'(NUM_STD - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_GATE_OFF  = 3'd1,
        ST_SELECT    = 3'd2,
        ST_WAIT_LOCK = 3'd3,
        ST_GATE_ON   = 3'd4,
        ST_HOLD      = 3'd5
    } state_t;

    state_t             state_r;
    logic [SEL_W-1:0]   chip_sel_r, tgt_r, pend_tgt_r;
    logic               clk_ce_r, rst_out_r, busy_r, done_r, pend_v_r;
    logic [CNT_W-1:0]   cnt_r, cnt_inc_s;
    logic               sw_meta_r, sw_sync_r, sw_ref_r, sw_req_r;
    logic [DEBOUNCE_W-1:0] db_cnt_r;
    logic [NUM_STD-1:0] lock_meta_r, lock_sync_r;
    logic               lock_cur_s;
    logic [SEL_W-1:0]   next_std_s, new_tgt_s, go_tgt_s;
    logic               new_req_s, go_s;

`ifdef STD_SWITCH_LOCK_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0]  to_cnt_r;
    logic [SEL_W-1:0] prev_sel_r;
    logic             to_done_r, pwrup_r, err_r;
`endif

    // Two-flop synchronizers for the raw switch and the PLL lock flags
    always_ff @(posedge clk_col4x or posedge rst) begin
        if (rst) begin
            sw_meta_r   <= 1'b0;
            sw_sync_r   <= 1'b0;
            lock_meta_r <= {NUM_STD{1'b0}};
            lock_sync_r <= {NUM_STD{1'b0}};
        end else begin
            sw_meta_r   <= standard_sw;
            sw_sync_r   <= sw_meta_r;
            lock_meta_r <= pll_locked;
            lock_sync_r <= lock_meta_r;
        end
    end

    // Debounce: a new switch level must hold for 2^DEBOUNCE_W cycles before it raises a request
    always_ff @(posedge clk_col4x or posedge rst) begin
        if (rst) begin
            sw_ref_r <= 1'b0;
            db_cnt_r <= {DEBOUNCE_W{1'b0}};
            sw_req_r <= 1'b0;
        end else if (sw_sync_r == sw_ref_r) begin
            db_cnt_r <= {DEBOUNCE_W{1'b0}};
            sw_req_r <= 1'b0;
        end else if (db_cnt_r == {DEBOUNCE_W{1'b1}}) begin
            sw_ref_r <= sw_sync_r;
            db_cnt_r <= {DEBOUNCE_W{1'b0}};
            sw_req_r <= 1'b1;
        end else begin
            db_cnt_r <= db_cnt_r + {{(DEBOUNCE_W-1){1'b0}}, 1'b1};
            sw_req_r <= 1'b0;
        end
    end

    // Next standard for a switch request and the saturating phase counter increment
    always_comb begin
        next_std_s = chip_sel_r + {{(SEL_W-1){1'b0}}, 1'b1};
        cnt_inc_s  = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        lock_cur_s = lock_sync_r[chip_sel_r];
        if (chip_sel_r == SEL_LAST) begin
            next_std_s = {SEL_W{1'b0}};
        end else begin
            next_std_s = chip_sel_r + {{(SEL_W-1){1'b0}}, 1'b1};
        end
        if (cnt_r == {CNT_W{1'b1}}) begin
            cnt_inc_s = cnt_r;
        end else begin
            cnt_inc_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Request arbitration: a valid register write beats a same-cycle switch request
    always_comb begin
        new_req_s = 1'b0;
        new_tgt_s = next_std_s;
        go_s      = 1'b0;
        go_tgt_s  = pend_tgt_r;
        if (req_valid && (int'(req_std) < NUM_STD)) begin
            new_req_s = 1'b1;
            new_tgt_s = req_std;
        end else if (sw_req_r) begin
            new_req_s = 1'b1;
            new_tgt_s = next_std_s;
        end else begin
            new_req_s = 1'b0;
        end
        // A fresh request supersedes the pending slot; either is dropped if it names the current standard
        if (new_req_s) begin
            go_s     = (new_tgt_s != chip_sel_r);
            go_tgt_s = new_tgt_s;
        end else if (pend_v_r) begin
            go_s     = (pend_tgt_r != chip_sel_r);
            go_tgt_s = pend_tgt_r;
        end else begin
            go_s = 1'b0;
        end
    end

    // Sequencer FSM; reset lands in WAIT_LOCK so power-up runs the lock/ungate/release tail
    always_ff @(posedge clk_col4x or posedge rst) begin
        if (rst) begin
            state_r    <= ST_WAIT_LOCK;
            chip_sel_r <= SEL_DEF;
            tgt_r      <= SEL_DEF;
            pend_tgt_r <= SEL_DEF;
            pend_v_r   <= 1'b0;
            clk_ce_r   <= 1'b0;
            rst_out_r  <= 1'b1;
            busy_r     <= 1'b1;
            done_r     <= 1'b0;
            cnt_r      <= {CNT_W{1'b0}};
`ifdef STD_SWITCH_LOCK_TIMEOUT_EN
            to_cnt_r   <= {TO_W{1'b0}};
            prev_sel_r <= SEL_DEF;
            to_done_r  <= 1'b0;
            pwrup_r    <= 1'b1;
            err_r      <= 1'b0;
`endif
        end else begin
            done_r <= 1'b0;
            if (state_r != ST_IDLE) begin
                if (new_req_s) begin
                    pend_v_r   <= 1'b1;
                    pend_tgt_r <= new_tgt_s;
                end
            end else begin
                pend_v_r <= 1'b0;
            end
            case (state_r)
                ST_IDLE: begin
                    if (go_s) begin
                        state_r   <= ST_GATE_OFF;
                        tgt_r     <= go_tgt_s;
                        clk_ce_r  <= 1'b0;
                        rst_out_r <= 1'b1;
                        busy_r    <= 1'b1;
                        cnt_r     <= {CNT_W{1'b0}};
`ifdef STD_SWITCH_LOCK_TIMEOUT_EN
                        err_r     <= 1'b0;
`endif
                    end
                end
                ST_GATE_OFF: begin
                    if (cnt_r == GATE_LAST) begin
                        state_r <= ST_SELECT;
                        cnt_r   <= {CNT_W{1'b0}};
                    end else begin
                        cnt_r <= cnt_inc_s;
                    end
                end
                ST_SELECT: begin
                    chip_sel_r <= tgt_r;
                    state_r    <= ST_WAIT_LOCK;
                    cnt_r      <= {CNT_W{1'b0}};
`ifdef STD_SWITCH_LOCK_TIMEOUT_EN
                    prev_sel_r <= chip_sel_r;
                    to_cnt_r   <= {TO_W{1'b0}};
                    to_done_r  <= 1'b0;
`endif
                end
                ST_WAIT_LOCK: begin
                    if (lock_cur_s && (cnt_r == SETTLE_LAST)) begin
                        state_r <= ST_GATE_ON;
                        cnt_r   <= {CNT_W{1'b0}};
                    end else begin
                        cnt_r <= lock_cur_s ? cnt_inc_s : {CNT_W{1'b0}};
`ifdef STD_SWITCH_LOCK_TIMEOUT_EN
                        if (to_cnt_r != {TO_W{1'b1}}) begin
                            to_cnt_r <= to_cnt_r + {{(TO_W-1){1'b0}}, 1'b1};
                        end
                        // One timeout per attempt; after power-up it also falls back to the old standard
                        if ((to_cnt_r == TO_LAST) && !to_done_r) begin
                            err_r     <= 1'b1;
                            to_done_r <= 1'b1;
                            if (!pwrup_r) begin
                                chip_sel_r <= prev_sel_r;
                                cnt_r      <= {CNT_W{1'b0}};
                            end
                        end
`endif
                    end
                end
                ST_GATE_ON: begin
                    if (cnt_r == GATE_LAST) begin
                        state_r  <= ST_HOLD;
                        clk_ce_r <= 1'b1;
                        cnt_r    <= {CNT_W{1'b0}};
                    end else begin
                        cnt_r <= cnt_inc_s;
                    end
                end
                ST_HOLD: begin
                    if (cnt_r == HOLD_LAST) begin
                        state_r   <= ST_IDLE;
                        rst_out_r <= 1'b0;
                        busy_r    <= 1'b0;
                        done_r    <= 1'b1;
                        cnt_r     <= {CNT_W{1'b0}};
`ifdef STD_SWITCH_LOCK_TIMEOUT_EN
                        pwrup_r   <= 1'b0;
`endif
                    end else begin
                        cnt_r <= cnt_inc_s;
                    end
                end
                default: begin
                    state_r   <= ST_WAIT_LOCK;
                    clk_ce_r  <= 1'b0;
                    rst_out_r <= 1'b1;
                    busy_r    <= 1'b1;
                    cnt_r     <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    assign chip_sel    = chip_sel_r;
    assign clk_ce      = clk_ce_r;
    assign rst_out     = rst_out_r;
    assign busy        = busy_r;
    assign switch_done = done_r;
`ifdef STD_SWITCH_LOCK_TIMEOUT_EN
    assign switch_err  = err_r;
`else
    assign switch_err  = 1'b0;
`endif

endmodule

// File: tb/tb_std_switch_seq.sv
// Scoreboard bench for std_switch_seq: directed requests push expected end states, a monitor checks each switch_done.
module tb_std_switch_seq;
    localparam int NUM_STD = 3;
    localparam int SEL_W   = 2;

    logic               clk_col4x = 1'b0;
    logic               rst;
    logic               standard_sw;
    logic [NUM_STD-1:0] pll_locked;
    logic               req_valid;
    logic [SEL_W-1:0]   req_std;
    logic [SEL_W-1:0]   chip_sel;
    logic               clk_ce, rst_out, busy, switch_done, switch_err;

    typedef struct packed {
        logic [SEL_W-1:0] sel;
        logic             err;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    logic [SEL_W-1:0] prev_sel_q;

    std_switch_seq #(
        .NUM_STD(NUM_STD), .SEL_W(SEL_W), .DEFAULT_STD(0), .DEBOUNCE_W(4),
        .GATE_CYCLES(4), .SETTLE_CYCLES(16), .RESET_HOLD(8), .TIMEOUT_CYCLES(64)
    ) dut (
        .clk_col4x(clk_col4x), .rst(rst), .standard_sw(standard_sw), .pll_locked(pll_locked),
        .req_valid(req_valid), .req_std(req_std), .chip_sel(chip_sel), .clk_ce(clk_ce),
        .rst_out(rst_out), .busy(busy), .switch_done(switch_done), .switch_err(switch_err)
    );

    always #5 clk_col4x = ~clk_col4x;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    task automatic tick();
        @(posedge clk_col4x);
        #1;
    endtask

    task automatic wait_done(input string name, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            if (switch_done) seen = 1'b1;
        end
        check(name, seen, 1);
    endtask

    task automatic reg_req(input logic [SEL_W-1:0] s);
        req_valid = 1'b1;
        req_std   = s;
        tick();
        req_valid = 1'b0;
    endtask

    // Scoreboard monitor: each switch_done is matched against the oldest expected end state
    always @(negedge clk_col4x) begin
        if (!rst && switch_done) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_done: got switch to %0d, expected no switch", chip_sel);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("done_sel", chip_sel, e.sel);
                check("done_err", switch_err, e.err);
                check("done_clk_ce", clk_ce, 1);
                check("done_rst_out", rst_out, 0);
            end
        end
    end

    // Select must only move while the clock buffers are gated
    always @(negedge clk_col4x) begin
        if (!rst && (chip_sel != prev_sel_q)) check("sel_change_gated", clk_ce, 0);
        prev_sel_q <= chip_sel;
    end

    initial begin
        int ce_rise, rst_fall, sel_at;
        rst = 1'b1; standard_sw = 1'b0; pll_locked = 3'b001; req_valid = 1'b0; req_std = 2'd0;
        exp_q.push_back('{sel: 2'd0, err: 1'b0});
        repeat (3) tick();
        check("rst_chip_sel", chip_sel, 0);
        check("rst_clk_ce", clk_ce, 0);
        check("rst_rst_out", rst_out, 1);
        check("rst_busy", busy, 1);
        check("rst_done", switch_done, 0);
        check("rst_err", switch_err, 0);

        // Power-up: 2 sync + 16 settle + 4 gate, then 8 hold
        rst = 1'b0;
        ce_rise = -1; rst_fall = -1;
        for (int c = 1; c <= 100 && rst_fall < 0; c++) begin
            tick();
            if (clk_ce && ce_rise < 0) ce_rise = c;
            if (!rst_out && rst_fall < 0) begin
                rst_fall = c;
                check("pwrup_done_at_rst_fall", switch_done, 1);
            end
        end
        check("pwrup_ce_rise", ce_rise, 22);
        check("pwrup_rst_fall", rst_fall, 30);
        tick();
        check("pwrup_idle", busy, 0);

        // Register request 0 -> 1
        pll_locked = 3'b011;
        repeat (4) tick();
        exp_q.push_back('{sel: 2'd1, err: 1'b0});
        reg_req(2'd1);
        check("req_ce_fall", clk_ce, 0);
        check("req_busy", busy, 1);
        sel_at = -1;
        for (int c = 1; c <= 20 && sel_at < 0; c++) begin
            tick();
            if (chip_sel == 2'd1) sel_at = c;
        end
        check("sel_change_delay", sel_at, 5);
        wait_done("req1_done", 100);

        // Short glitch on the switch is ignored
        repeat (2) tick();
        standard_sw = 1'b1;
        repeat (8) tick();
        standard_sw = 1'b0;
        repeat (40) tick();
        check("glitch_no_busy", busy, 0);
        check("glitch_sel", chip_sel, 1);

        // Stable switch edges: 1 -> 2, then wrap 2 -> 0
        pll_locked = 3'b111;
        exp_q.push_back('{sel: 2'd2, err: 1'b0});
        standard_sw = 1'b1;
        wait_done("sw_rise_done", 200);
        repeat (2) tick();
        exp_q.push_back('{sel: 2'd0, err: 1'b0});
        standard_sw = 1'b0;
        wait_done("sw_wrap_done", 200);

        // Out-of-range and same-standard requests are dropped
        repeat (2) tick();
        reg_req(2'd3);
        check("oob_req_ce", clk_ce, 1);
        reg_req(2'd0);
        check("same_req_ce", clk_ce, 1);
        repeat (5) tick();
        check("dropped_busy", busy, 0);
        check("dropped_sel", chip_sel, 0);

        // Requests 1 then 2 while busy: only the last pending one is served
        exp_q.push_back('{sel: 2'd1, err: 1'b0});
        reg_req(2'd1);
        repeat (3) tick();
        reg_req(2'd1);
        reg_req(2'd2);
        exp_q.push_back('{sel: 2'd2, err: 1'b0});
        wait_done("pend_first_done", 100);
        wait_done("pend_second_done", 100);
        repeat (60) tick();
        check("pend_no_extra", busy, 0);
        check("pend_sel", chip_sel, 2);

`ifdef STD_SWITCH_LOCK_TIMEOUT_EN
        // Target PLL never locks: fall back to 2 with switch_err, next request clears it
        pll_locked = 3'b101;
        repeat (4) tick();
        exp_q.push_back('{sel: 2'd2, err: 1'b1});
        reg_req(2'd1);
        wait_done("timeout_done", 300);
        repeat (2) tick();
        check("err_sticky", switch_err, 1);
        exp_q.push_back('{sel: 2'd0, err: 1'b0});
        reg_req(2'd0);
        check("err_cleared", switch_err, 0);
        wait_done("after_timeout_done", 200);
        repeat (2) tick();
`endif

        // Reset during WAIT_LOCK of a switch to 1
        pll_locked = 3'b101;
        repeat (4) tick();
        reg_req(2'd1);
        sel_at = -1;
        for (int c = 1; c <= 20 && sel_at < 0; c++) begin
            tick();
            if (chip_sel == 2'd1) sel_at = c;
        end
        check("abort_sel_reached", sel_at, 5);
        repeat (3) tick();
        #2 rst = 1'b1;
        #1;
        check("abort_chip_sel", chip_sel, 0);
        check("abort_clk_ce", clk_ce, 0);
        check("abort_rst_out", rst_out, 1);
        check("abort_busy", busy, 1);
        exp_q.push_back('{sel: 2'd0, err: 1'b0});
        tick();
        tick();
        rst = 1'b0;
        wait_done("abort_pwrup_done", 100);
        repeat (5) tick();
        check("queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
